// File: rtl/seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
//
// Receive-side counterpart of the board's 7-segment character encoder. A raw
// segment pattern is debounced, decoded back to its 6-bit character code
// (hex table or letter table) and queued in a small FIFO with a valid/ready
// handshake. Patterns that match no table entry are reported and counted.
//
// Code space:
//   0..15   hex digits 0-F                (mode = 0)
//   16..41  letters A b C c d E F g H h I i J L n O o P q r S t U u y deg
//                                         (mode = 1)
//   62      dash (7'h40), either mode
//   63      unknown pattern, either mode
//
// Ports:
//   clk_2       in   1          system clock (only clock)
//   reset_n     in   1          synchronous active-low reset
//   seg_in      in   7          segment pattern {g,f,e,d,c,b,a}, 1 = lit
//   mode        in   1          0 = hex table, 1 = letter table (sampled at accept)
//   code_out    out  6          FIFO head code, 0 when empty
//   code_valid  out  1          FIFO non-empty
//   code_ready  in   1          consumer pop strobe
//   err         out  1          one-cycle pulse when an unknown pattern is accepted
//   err_cnt     out  ERR_W      saturating count of unknown patterns
//   overflow    out  1          sticky: a push was dropped because the FIFO was full
//   fifo_count  out  clog2(D)+1 FIFO occupancy
//
// Optional build macro SEG7_GRADE_DECODE_EN adds:
//   grade_mode  in   1          1 = decode accepted pattern as a grade class
//   grade_out   out  2          last grade class (1 fail, 2 final exam, 3 approved)
// In grade mode nothing is pushed to the FIFO; unknown grades pulse err.
// -----------------------------------------------------------------------------
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_W         = 8
) (
    input  logic                          clk_2,
    input  logic                          reset_n,
    input  logic [6:0]                    seg_in,
    input  logic                          mode,
`ifdef SEG7_GRADE_DECODE_EN
    input  logic                          grade_mode,
    output logic [1:0]                    grade_out,
`endif
    output logic [5:0]                    code_out,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic                          err,
    output logic [ERR_W-1:0]              err_cnt,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STAB_W = $clog2(STABLE_CYCLES);

    localparam logic [STAB_W-1:0] STAB_ACCEPT = STAB_W'(STABLE_CYCLES - 2);
    localparam logic [STAB_W-1:0] STAB_MAX    = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

    localparam logic [5:0] CODE_DASH    = 6'd62;
    localparam logic [5:0] CODE_UNKNOWN = 6'd63;

    // -------------------------------------------------------------------------
    // Decode tables
    // -------------------------------------------------------------------------
    function automatic logic [5:0] decode_hex(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode_hex = 6'd0;
            7'h06:   decode_hex = 6'd1;
            7'h5B:   decode_hex = 6'd2;
            7'h4F:   decode_hex = 6'd3;
            7'h66:   decode_hex = 6'd4;
            7'h6D:   decode_hex = 6'd5;
            7'h7D:   decode_hex = 6'd6;
            7'h07:   decode_hex = 6'd7;
            7'h7F:   decode_hex = 6'd8;
            7'h6F:   decode_hex = 6'd9;
            7'h77:   decode_hex = 6'd10;
            7'h7C:   decode_hex = 6'd11;
            7'h39:   decode_hex = 6'd12;
            7'h5E:   decode_hex = 6'd13;
            7'h79:   decode_hex = 6'd14;
            7'h71:   decode_hex = 6'd15;
            default: decode_hex = CODE_UNKNOWN;
        endcase
    endfunction

    function automatic logic [5:0] decode_letter(input logic [6:0] seg);
        case (seg)
            7'h77:   decode_letter = 6'd16;  // A
            7'h7C:   decode_letter = 6'd17;  // b
            7'h39:   decode_letter = 6'd18;  // C
            7'h58:   decode_letter = 6'd19;  // c
            7'h5E:   decode_letter = 6'd20;  // d
            7'h79:   decode_letter = 6'd21;  // E
            7'h71:   decode_letter = 6'd22;  // F
            7'h6F:   decode_letter = 6'd23;  // g
            7'h76:   decode_letter = 6'd24;  // H
            7'h74:   decode_letter = 6'd25;  // h
            7'h06:   decode_letter = 6'd26;  // I
            7'h04:   decode_letter = 6'd27;  // i
            7'h1E:   decode_letter = 6'd28;  // J
            7'h38:   decode_letter = 6'd29;  // L
            7'h54:   decode_letter = 6'd30;  // n
            7'h3F:   decode_letter = 6'd31;  // O
            7'h5C:   decode_letter = 6'd32;  // o
            7'h73:   decode_letter = 6'd33;  // P
            7'h67:   decode_letter = 6'd34;  // q
            7'h50:   decode_letter = 6'd35;  // r
            7'h6D:   decode_letter = 6'd36;  // S
            7'h78:   decode_letter = 6'd37;  // t
            7'h3E:   decode_letter = 6'd38;  // U
            7'h1C:   decode_letter = 6'd39;  // u
            7'h6E:   decode_letter = 6'd40;  // y
            7'h63:   decode_letter = 6'd41;  // degree sign
            default: decode_letter = CODE_UNKNOWN;
        endcase
    endfunction

    // Dash is shared by both tables, so it is checked before the mode split.
    function automatic logic [5:0] decode_char(input logic [6:0] seg, input logic letter);
        if (seg == 7'h40)
            decode_char = CODE_DASH;
        else if (letter)
            decode_char = decode_letter(seg);
        else
            decode_char = decode_hex(seg);
    endfunction

`ifdef SEG7_GRADE_DECODE_EN
    // Grade class 0 doubles as "unknown".
    function automatic logic [1:0] decode_grade(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode_grade = 2'd1;
            7'h71:   decode_grade = 2'd2;
            7'h77:   decode_grade = 2'd3;
            default: decode_grade = 2'd0;
        endcase
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [6:0]        seg_q;
    logic [STAB_W-1:0] stab_cnt;
    logic [6:0]        last_accepted;

    logic [5:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // -------------------------------------------------------------------------
    // Stage p0: stability check, accept and decode (combinational on seg_in)
    // -------------------------------------------------------------------------
    logic       stable_p0;
    logic       accept_p0;
    logic       blank_p0;
    logic       grade_sel_p0;
    logic [5:0] code_p0;
    logic       unknown_p0;
    logic       push_p0;
    logic       pop_p0;
    logic       full_p0;
    logic       do_push_p0;
    logic       drop_p0;
`ifdef SEG7_GRADE_DECODE_EN
    logic [1:0] grade_p0;
`endif

    always_comb begin
        stable_p0    = (seg_in == seg_q);
        // The counter saturates one above the accept value, so a pattern held
        // indefinitely accepts exactly once.
        accept_p0    = stable_p0 && (stab_cnt == STAB_ACCEPT) && (seg_in != last_accepted);
        blank_p0     = (seg_in == 7'h00);
        code_p0      = decode_char(seg_in, mode);
        grade_sel_p0 = 1'b0;
`ifdef SEG7_GRADE_DECODE_EN
        grade_p0     = decode_grade(seg_in);
        grade_sel_p0 = grade_mode;
`endif

        unknown_p0 = 1'b0;
        if (accept_p0 && !blank_p0) begin
`ifdef SEG7_GRADE_DECODE_EN
            if (grade_sel_p0)
                unknown_p0 = (grade_p0 == 2'd0);
            else
                unknown_p0 = (code_p0 == CODE_UNKNOWN);
`else
            unknown_p0 = (code_p0 == CODE_UNKNOWN);
`endif
        end

        // Blank only re-arms last_accepted; it never produces a code.
        push_p0    = accept_p0 && !blank_p0 && !grade_sel_p0;
        pop_p0     = (count != '0) && code_ready;
        full_p0    = (count == CNT_FULL);
        // A pop on the same edge frees the slot the push needs.
        do_push_p0 = push_p0 && (!full_p0 || pop_p0);
        drop_p0    = push_p0 && full_p0 && !pop_p0;
    end

    // -------------------------------------------------------------------------
    // Stage p1: registered control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            seg_q         <= '0;
            stab_cnt      <= '0;
            last_accepted <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err           <= 1'b0;
            err_cnt       <= '0;
            overflow      <= 1'b0;
`ifdef SEG7_GRADE_DECODE_EN
            grade_out     <= 2'd0;
`endif
        end else begin
            seg_q <= seg_in;

            if (!stable_p0)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + STAB_W'(1);

            if (accept_p0)
                last_accepted <= seg_in;

            err <= unknown_p0;
            if (unknown_p0 && (err_cnt != ERR_MAX))
                err_cnt <= err_cnt + ERR_W'(1);

            if (drop_p0)
                overflow <= 1'b1;

            if (do_push_p0)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_p0)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case ({do_push_p0, pop_p0})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

`ifdef SEG7_GRADE_DECODE_EN
            if (accept_p0 && !blank_p0 && grade_sel_p0)
                grade_out <= grade_p0;
`endif
        end
    end

    // FIFO storage carries data only; occupancy gates what is visible.
    always_ff @(posedge clk_2) begin
        if (do_push_p0)
            fifo_mem[wr_ptr] <= code_p0;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign code_valid = (count != '0);
    assign code_out   = code_valid ? fifo_mem[rd_ptr] : 6'd0;
    assign fifo_count = count;

endmodule

// File: tb/tb_seg7_decoder.sv
module tb_seg7_decoder;

    logic       clk_2;
    logic       reset_n;
    logic [6:0] seg_in;
    logic       mode;
    logic [5:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic       err;
    logic [7:0] err_cnt;
    logic       overflow;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] exp_q [$];

    seg7_decoder #(
        .STABLE_CYCLES(4),
        .FIFO_DEPTH   (4),
        .ERR_W        (8)
    ) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .mode      (mode),
        .code_out  (code_out),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .err       (err),
        .err_cnt   (err_cnt),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic hold(input logic [6:0] pat, input int n);
        seg_in = pat;
        repeat (n) tick();
    endtask

    // Monitor: every handshake pops the next expected code from the scoreboard.
    always @(negedge clk_2) begin
        if (reset_n && code_valid && code_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got code %0d, expected no entry", code_out);
            end else begin
                chk("pop_code", {26'd0, code_out}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        seg_in     = 7'h00;
        mode       = 1'b0;
        code_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;

        chk("rst_valid",    code_valid, 0);
        chk("rst_code",     code_out,   0);
        chk("rst_count",    fifo_count, 0);
        chk("rst_err",      err,        0);
        chk("rst_err_cnt",  err_cnt,    0);
        chk("rst_overflow", overflow,   0);

        // Letter A: accept on the 4th edge of the hold.
        mode = 1'b1;
        hold(7'h77, 3);
        chk("A_not_yet", code_valid, 0);
        exp_q.push_back(6'd16);
        tick();
        chk("A_valid", code_valid, 1);
        chk("A_code",  code_out,   16);
        chk("A_count", fifo_count, 1);
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        chk("A_pop_valid", code_valid, 0);
        chk("A_pop_code",  code_out,   0);

        // 6F as hex 9, then as letter g after a blank; long hold pushes once.
        hold(7'h00, 4);
        mode = 1'b0;
        exp_q.push_back(6'd9);
        hold(7'h6F, 4);
        hold(7'h00, 4);
        mode = 1'b1;
        exp_q.push_back(6'd23);
        hold(7'h6F, 20);
        chk("g_count_once", fifo_count, 2);
        code_ready = 1'b1;
        repeat (2) tick();
        code_ready = 1'b0;
        chk("g_drained", fifo_count, 0);

        // Bouncing input never settles long enough to accept.
        for (int i = 0; i < 10; i++)
            hold((i % 2 == 0) ? 7'h06 : 7'h5B, 2);
        chk("bounce_count", fifo_count, 0);
        chk("bounce_valid", code_valid, 0);

        exp_q.push_back(6'd62);
        hold(7'h40, 4);
        chk("dash_code", code_out, 62);
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;

        // Unknown pattern: single err pulse, counted, code 63 queued.
        exp_q.push_back(6'd63);
        hold(7'h7E, 3);
        chk("unk_err_before", err, 0);
        tick();
        chk("unk_err_pulse", err,      1);
        chk("unk_err_cnt",   err_cnt,  1);
        chk("unk_code",      code_out, 63);
        tick();
        chk("unk_err_end", err, 0);

        // Drive err_cnt to saturation while the consumer drains the 63s.
        code_ready = 1'b1;
        for (int i = 0; i < 254; i++) begin
            hold(7'h00, 4);
            exp_q.push_back(6'd63);
            hold(7'h7E, 4);
        end
        chk("err_cnt_max", err_cnt, 255);
        hold(7'h00, 4);
        exp_q.push_back(6'd63);
        hold(7'h7E, 4);
        chk("err_cnt_sat", err_cnt, 255);
        repeat (2) tick();
        code_ready = 1'b0;
        chk("sat_drained",  fifo_count, 0);
        chk("sat_no_ovf",   overflow,   0);

        // Overflow: 5 hex codes with no consumer; the 5th is dropped.
        mode = 1'b0;
        exp_q.push_back(6'd0);
        hold(7'h3F, 4);
        exp_q.push_back(6'd1);
        hold(7'h06, 4);
        exp_q.push_back(6'd2);
        hold(7'h5B, 4);
        exp_q.push_back(6'd3);
        hold(7'h4F, 4);
        chk("full_count",   fifo_count, 4);
        chk("full_no_ovf",  overflow,   0);
        hold(7'h66, 4);
        chk("drop_count",   fifo_count, 4);
        chk("drop_ovf",     overflow,   1);

        // Push and pop on the same edge while full.
        exp_q.push_back(6'd5);
        hold(7'h6D, 3);
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        chk("pp_count", fifo_count, 4);
        chk("pp_ovf",   overflow,   1);
        chk("pp_head",  code_out,   1);
        code_ready = 1'b1;
        repeat (4) tick();
        code_ready = 1'b0;
        chk("pp_drained", fifo_count, 0);

        // Reset mid-operation with 3 queued entries and a partial count.
        hold(7'h77, 4);
        hold(7'h7C, 4);
        hold(7'h39, 4);
        chk("pre_rst_count", fifo_count, 3);
        hold(7'h5E, 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_valid",    code_valid, 0);
        chk("mid_rst_code",     code_out,   0);
        chk("mid_rst_count",    fifo_count, 0);
        chk("mid_rst_err",      err,        0);
        chk("mid_rst_err_cnt",  err_cnt,    0);
        chk("mid_rst_overflow", overflow,   0);

        // Last pattern before reset is accepted again.
        hold(7'h39, 3);
        chk("reacc_not_yet", fifo_count, 0);
        exp_q.push_back(6'd12);
        tick();
        chk("reacc_count", fifo_count, 1);
        chk("reacc_code",  code_out,   12);
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
